// File: rtl/spi_reg_bank_arbiter_if.sv
// Bus bundle between the register bank and its two requesters (SPI slave and core).
// The master drives the SPI and core request signals; the slave is the register bank.
interface spi_reg_bank_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0]      spi_addr;
  logic [REG_W-1:0]       spi_wdata;
  logic                   spi_wvld;
  logic [REG_W-1:0]       spi_rdata;
  logic [5:0]             fastcmd;
  logic                   fastcmd_vld;
  logic                   core_req;
  logic                   core_we;
  logic [ADDR_W-1:0]      core_addr;
  logic [REG_W-1:0]       core_wdata;
  logic                   core_ack;
  logic                   core_err;
  logic [REG_W-1:0]       core_rdata;
  logic [7:0]             status;
  logic [REG_W*DEPTH-1:0] regs_flat;

  modport master (
    output spi_addr, spi_wdata, spi_wvld, fastcmd, fastcmd_vld,
           core_req, core_we, core_addr, core_wdata,
    input  spi_rdata, core_ack, core_err, core_rdata, status, regs_flat
  );

  modport slave (
    input  spi_addr, spi_wdata, spi_wvld, fastcmd, fastcmd_vld,
           core_req, core_we, core_addr, core_wdata,
    output spi_rdata, core_ack, core_err, core_rdata, status, regs_flat
  );
endinterface

// File: rtl/spi_reg_bank_arbiter.sv
// Register bank shared between a non-stallable SPI write port and a req/ack core port,
// with SPI fast commands (clear, lock, unlock, flag clear) and a registered status byte.
module spi_reg_bank_arbiter #(
  parameter int               ADDR_W    = 3,
  parameter int               REG_W     = 8,
  parameter logic [REG_W-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_reg_bank_arbiter_if.slave bus,
  output logic                  state_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  localparam logic [5:0] CMD_CLEAR     = 6'h01;
  localparam logic [5:0] CMD_LOCK      = 6'h02;
  localparam logic [5:0] CMD_UNLOCK    = 6'h03;
  localparam logic [5:0] CMD_CLR_FLAGS = 6'h04;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [REG_W-1:0]  regs_q [DEPTH];
  logic [REG_W-1:0]  regs_d [DEPTH];
  logic              locked_q, locked_d;
  logic              spi_drop_q, spi_drop_d;
  logic              unk_cmd_q, unk_cmd_d;
  logic              core_pend_q, core_pend_d;
  logic              core_ack_q, core_ack_d;
  logic              core_err_q, core_err_d;
  logic [REG_W-1:0]  core_rdata_q, core_rdata_d;
  logic [REG_W-1:0]  spi_rdata_q;
  logic              accept;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    regs_d       = regs_q;
    locked_d     = locked_q;
    spi_drop_d   = spi_drop_q;
    unk_cmd_d    = unk_cmd_q;
    core_ack_d   = 1'b0;
    core_err_d   = 1'b0;
    core_rdata_d = core_rdata_q;
    accept       = 1'b0;
    // Registered copy of core_req && !core_ack keeps status free of input paths.
    core_pend_d  = bus.core_req && !core_ack_q;

    case (state_q)
      IDLE: begin
        // The ack cycle is never an accept cycle, giving one access per two cycles.
        accept = bus.core_req && !bus.spi_wvld && !core_ack_q;
        if (bus.spi_wvld) begin
          regs_d[bus.spi_addr] = bus.spi_wdata;
        end else if (accept && bus.core_we && !locked_q) begin
          regs_d[bus.core_addr] = bus.core_wdata;
        end
        if (accept) begin
          core_ack_d   = 1'b1;
          core_err_d   = bus.core_we && locked_q;
          core_rdata_d = regs_q[bus.core_addr];
        end
        if (bus.fastcmd_vld) begin
          case (bus.fastcmd)
            CMD_CLEAR: begin
              state_d   = CLEAR;
              clr_idx_d = '0;
            end
            CMD_LOCK:      locked_d = 1'b1;
            CMD_UNLOCK:    locked_d = 1'b0;
            CMD_CLR_FLAGS: begin
              spi_drop_d = 1'b0;
              unk_cmd_d  = 1'b0;
            end
            default:       unk_cmd_d = 1'b1;
          endcase
        end
      end
      CLEAR: begin
        regs_d[clr_idx_q] = RESET_VAL;
        clr_idx_d         = clr_idx_q + IDX_ONE;
        if (clr_idx_q == {ADDR_W{1'b1}}) state_d = IDLE;
        if (bus.spi_wvld) spi_drop_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clr_idx_q    <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
      locked_q     <= 1'b0;
      spi_drop_q   <= 1'b0;
      unk_cmd_q    <= 1'b0;
      core_pend_q  <= 1'b0;
      core_ack_q   <= 1'b0;
      core_err_q   <= 1'b0;
      core_rdata_q <= '0;
      spi_rdata_q  <= RESET_VAL;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      regs_q       <= regs_d;
      locked_q     <= locked_d;
      spi_drop_q   <= spi_drop_d;
      unk_cmd_q    <= unk_cmd_d;
      core_pend_q  <= core_pend_d;
      core_ack_q   <= core_ack_d;
      core_err_q   <= core_err_d;
      core_rdata_q <= core_rdata_d;
      spi_rdata_q  <= regs_q[bus.spi_addr];
    end
  end

  assign bus.spi_rdata  = spi_rdata_q;
  assign bus.core_ack   = core_ack_q;
  assign bus.core_err   = core_err_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.status     = {state_q == CLEAR, locked_q, core_pend_q, spi_drop_q, unk_cmd_q, 3'b000};
  assign state_o        = (state_q == CLEAR);

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign bus.regs_flat[i*REG_W +: REG_W] = regs_q[i];
  end
endmodule

// File: doc/spi_reg_bank_arbiter.md
# spi_reg_bank_arbiter

Register bank and access controller behind the SPI register slave. It owns 2^ADDR_W registers of REG_W bits and shares them between two requesters:
- the SPI slave's write-strobe/read port, which cannot be stalled;
- an on-chip core port using a req/ack handshake.

It also executes SPI fast commands (bank clear, lock, unlock, flag clear) and produces the 8-bit status byte the SPI slave returns at the start of every frame.

## Interface
- ADDR_W, 3, register address width; bank depth is 2^ADDR_W
- REG_W, 8, register width in bits
- RESET_VAL, 0, value loaded into every register on reset and by CLEAR
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spi_addr  in  ADDR_W  SPI register address
- spi_wdata  in  REG_W  SPI write data
- spi_wvld  in  1  single-cycle SPI write strobe
- spi_rdata  out  REG_W  registered read of regs[spi_addr]
- fastcmd  in  6  fast command code
- fastcmd_vld  in  1  single-cycle fast command strobe
- core_req  in  1  core access request, held until core_ack
- core_we  in  1  1 = write, 0 = read; stable while core_req is high
- core_addr  in  ADDR_W  core address; stable while core_req is high
- core_wdata  in  REG_W  core write data; stable while core_req is high
- core_ack  out  1  single-cycle completion pulse
- core_err  out  1  valid with core_ack; 1 = write rejected (locked)
- core_rdata  out  REG_W  regs[core_addr] at accept; valid with core_ack
- status  out  8  {busy, locked, core_pend, spi_drop, unk_cmd, 3'b000}
- regs_flat  out  REG_W*2^ADDR_W  all registers; reg i at [i*REG_W +: REG_W]

## Operation
- **FSM states:** IDLE, CLEAR. Reset enters IDLE.
- **SPI writes:**
  - In IDLE, spi_wvld writes spi_wdata to regs[spi_addr] that cycle.
  - SPI writes always win over the core port.
  - Lock does not affect SPI writes.
- **Core accept rule:** a core request is accepted in cycle T only when all of the following hold:
  - core_req=1;
  - state=IDLE;
  - spi_wvld=0;
  - core_ack is not high in T.
- **Core access effects:** on accept:
  - if core_we=1 and not locked: regs[core_addr] ← core_wdata;
  - if core_we=1 and locked: no write, core_err=1 with the ack;
  - reads are always allowed.
- **core_rdata:** always the pre-write value of regs[core_addr] at cycle T.
- **core_pend:** status bit, equal to core_req && !core_ack.
- **Fast commands** (sampled when fastcmd_vld=1 in IDLE):
  - 6'h01 CLEAR: go to CLEAR, clr_idx=0.
  - 6'h02 LOCK: locked=1.
  - 6'h03 UNLOCK: locked=0.
  - 6'h04 CLR_FLAGS: spi_drop=0, unk_cmd=0.
  - Any other code: unk_cmd=1 (sticky).
- **CLEAR state:**
  - Writes RESET_VAL to regs[clr_idx], one register per cycle, then increments clr_idx (ADDR_W bits).
  - After writing index 2^ADDR_W-1, returns to IDLE; CLEAR lasts exactly 2^ADDR_W cycles.
  - busy=1 throughout CLEAR.
  - spi_wvld during CLEAR: write dropped, spi_drop=1 (sticky).
  - Core requests are not accepted (stall, no error).
  - fastcmd_vld during CLEAR: ignored entirely; no flag change.
- **Simultaneous events in one IDLE cycle:**
  - spi_wvld + fastcmd CLEAR: the SPI write is performed, then CLEAR starts next cycle and overwrites it.
  - spi_wvld + core_req: SPI write only; the core request remains pending.
  - fastcmd LOCK + core write accept: lock takes effect from the next cycle; the accepted write proceeds.
- **Write visibility:** registers update at the clock edge ending the write cycle; regs_flat reflects them from the next cycle.

## Timing
- **Reset values:**
  - all regs=RESET_VAL;
  - spi_rdata=RESET_VAL;
  - core_ack=0, core_err=0, core_rdata=0;
  - locked=0, spi_drop=0, unk_cmd=0;
  - status=8'h00; state=IDLE.
- **Reset mid-CLEAR or mid-handshake:** everything returns to the reset values immediately; a pending core request is re-accepted after reset release.
- **spi_rdata:** registered each cycle from regs[spi_addr] as held before that cycle's write.
  - A write at T is visible on spi_rdata at T+2 when the address is unchanged.
  - The SPI slave samples reg_data_i many clk cycles after the address is stable, so this latency is sufficient.
- **Core handshake:**
  - accept at T → core_ack=1 at T+1 for one cycle, with core_err and core_rdata valid.
  - The requester drops or changes core_req after seeing ack.
  - The ack cycle itself is never an accept cycle, so maximum throughput is one access per 2 cycles.
- **Fast commands:**
  - LOCK/UNLOCK/CLR_FLAGS/unknown: effect visible in status at T+1.
  - CLEAR: busy=1 from T+1 through T+2^ADDR_W, IDLE at T+2^ADDR_W+1.
- **status:** registered, no combinational paths from inputs.

## Test plan
- **Reset and CLEAR:** reset; SPI write 8'hA5 to addr 2; fastcmd 6'h01 → busy=1 for 8 cycles, all regs 8'h00 after, status[7]=0.
- **Lock:** fastcmd 6'h02, core write addr 3 8'h5A → core_ack with core_err=1, reg 3 unchanged, status[6]=1; fastcmd 6'h03, repeat → core_err=0, reg 3=8'h5A.
- **SPI/core collision:** core write addr 1 8'h11 and spi_wvld addr 1 8'h22 in the same cycle → SPI write first, core accepted the next cycle, final reg 1=8'h11, core_ack two cycles after the collision.
- **Core read:** core read of addr 4 holding 8'h3C → core_ack one cycle after accept, core_rdata=8'h3C, core_err=0.
- **SPI write during CLEAR:** spi_wvld during CLEAR → write dropped, status[4]=1; unknown fastcmd 6'h3F → status[3]=1; fastcmd 6'h04 → status[4:3]=0.
- **Reset mid-CLEAR:** assert rst at cycle 3 of CLEAR → all outputs at reset values, state IDLE, busy=0 after release.
